// File: rtl/bitstream_generator.sv
// Unipolar stochastic number generator: latches a value, then streams LENGTH bits framed by capture.
// Latency: LEAD one cycle after an accepted start, done pulses LENGTH+2 cycles later; all outputs registered.
// Backpressure: none; start is honoured only in IDLE and ignored (never queued) while busy. Option macro: BITSTREAM_RESEED_EN.
module bitstream_generator #(
  parameter int WIDTH  = 8,
  parameter int LENGTH = 2**WIDTH-1,
  parameter int SEED   = 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] value,
  input  logic             start,
  output logic             bit_out,
  output logic             capture,
  output logic             busy,
  output logic             done
);

  // An all-zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [WIDTH-1:0] SEED_W   = WIDTH'(SEED);
  localparam logic [WIDTH-1:0] SEED_EFF = (SEED_W == '0) ? WIDTH'(1) : SEED_W;
  localparam logic [15:0]      LEN16    = 16'(LENGTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_STREAM,
    S_GAP1,
    S_GAP2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             bit_out_q, bit_out_d;
  logic             capture_q, capture_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fb;
  logic [WIDTH-1:0] lfsr_step;

  // Maximal-length feedback taps for the two supported widths.
  generate
    if (WIDTH == 16) begin : g_taps16
      assign fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    end else if (WIDTH == 8) begin : g_taps8
      assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    end else begin : g_bad_width
      $error("bitstream_generator: WIDTH must be 8 or 16");
      assign fb = 1'b0;
    end
  endgenerate

  // Fibonacci LFSR shifts left with feedback entering bit 0.
  assign lfsr_step = {lfsr_q[WIDTH-2:0], fb};

  // Next-state logic; outputs are derived from the next state so they can be registered.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    value_d   = value_q;
    cnt_d     = cnt_q;
    bit_out_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          value_d = value;
          cnt_d   = 16'd0;
          state_d = S_LEAD;
`ifdef BITSTREAM_RESEED_EN
          lfsr_d  = SEED_EFF;
`endif
        end
      end
      S_LEAD: begin
        // First stream bit is produced on the edge leaving LEAD.
        state_d   = S_STREAM;
        cnt_d     = 16'd1;
        bit_out_d = (lfsr_q <= value_q);
        lfsr_d    = lfsr_step;
      end
      S_STREAM: begin
        if (cnt_q == LEN16) begin
          state_d = S_GAP1;
        end else begin
          cnt_d     = cnt_q + 16'd1;
          bit_out_d = (lfsr_q <= value_q);
          lfsr_d    = lfsr_step;
        end
      end
      S_GAP1: state_d = S_GAP2;
      S_GAP2: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    capture_d = (state_d == S_LEAD) || (state_d == S_STREAM);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_GAP2);
  end

  // State, datapath and output registers; reset clears outputs immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED_EFF;
      value_q   <= '0;
      cnt_q     <= 16'd0;
      bit_out_q <= 1'b0;
      capture_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      value_q   <= value_d;
      cnt_q     <= cnt_d;
      bit_out_q <= bit_out_d;
      capture_q <= capture_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bit_out = bit_out_q;
  assign capture = capture_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_bitstream_generator.sv
// Directed bench for bitstream_generator: full-period exactness, framing, start/value isolation, reset.
// Two instances: A (WIDTH 8, LENGTH 255) and B (WIDTH 8, LENGTH 16, SEED 1).
// Each instance has a small integrator model counting ones while capture is high.
module tb_bitstream_generator;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [7:0] value_a = 8'd0, value_b = 8'd0;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic       bit_a, cap_a, busy_a, done_a;
  logic       bit_b, cap_b, busy_b, done_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bitstream_generator #(.WIDTH(8), .LENGTH(255), .SEED(1)) u_a (
    .clk(clk), .n_rst(n_rst), .value(value_a), .start(start_a),
    .bit_out(bit_a), .capture(cap_a), .busy(busy_a), .done(done_a)
  );

  bitstream_generator #(.WIDTH(8), .LENGTH(16), .SEED(1)) u_b (
    .clk(clk), .n_rst(n_rst), .value(value_b), .start(start_b),
    .bit_out(bit_b), .capture(cap_b), .busy(busy_b), .done(done_b)
  );

  // Per-stream monitor for A: restarts its counters on every busy rise.
  int   busy_cnt_a = 0, cap_cnt_a = 0, ones_a = 0, dones_a = 0, y_a = 0, streams_a = 0;
  logic busy_prev_a = 1'b0;
  always @(negedge clk) begin
    busy_prev_a <= busy_a;
    if (busy_a && !busy_prev_a) begin
      streams_a  <= streams_a + 1;
      busy_cnt_a <= 1;
      cap_cnt_a  <= int'(cap_a);
      ones_a     <= int'(cap_a & bit_a);
      dones_a    <= 0;
    end else begin
      if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
      if (cap_a) cap_cnt_a <= cap_cnt_a + 1;
      if (cap_a && bit_a) ones_a <= ones_a + 1;
      if (done_a) begin
        dones_a <= dones_a + 1;
        y_a     <= ones_a;
      end
    end
  end

  // Monitor for B: records the captured bit sequence (LEAD bit included) MSB-first.
  logic [16:0] bits_b = '0;
  logic        busy_prev_b = 1'b0;
  always @(negedge clk) begin
    busy_prev_b <= busy_b;
    if (busy_b && !busy_prev_b) bits_b <= {16'd0, bit_b};
    else if (cap_b) bits_b <= {bits_b[15:0], bit_b};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Waits for done on the selected instance; a timeout is reported as a failure.
  task automatic wait_done(input int sel, input int budget, input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel == 0 && done_a) || (sel == 1 && done_b)) begin
        seen = 1'b1;
        break;
      end
    end
    check(tag, 32'(seen), 32'd1);
  endtask

  // Pulses start on A for one cycle with the given value.
  task automatic pulse_a(input logic [7:0] v);
    @(negedge clk);
    value_a = v;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  function automatic logic [7:0] step8(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

  logic [7:0]  s;
  logic [16:0] exp_v, first_v;
  int          streams_before;

  initial begin
    // Reset state.
    #12;
    check("reset_outs", {28'd0, bit_a, cap_a, busy_a, done_a}, 32'd0);
    check("reset_lfsr", 32'(u_a.lfsr_q), 32'd1);
    @(negedge clk);
    n_rst = 1'b1;

    // value=100 over a full period: LEAD timing, window lengths, exact count.
    pulse_a(8'd100);
    check("lead_outs", {28'd0, bit_a, cap_a, busy_a, done_a}, 32'b0110);
    wait_done(0, 300, "done100_seen");
    @(negedge clk);
    check("idle_after_100", 32'(busy_a), 32'd0);
    @(negedge clk);
    check("busy_len", 32'(busy_cnt_a), 32'd258);
    check("cap_len", 32'(cap_cnt_a), 32'd256);
    check("y_100", 32'(y_a), 32'd100);
    check("done_once", 32'(dones_a), 32'd1);

    // Extremes: LFSR continues from the previous stream, count is still exact.
    pulse_a(8'd0);
    wait_done(0, 300, "done0_seen");
    @(negedge clk);
    @(negedge clk);
    check("y_0", 32'(y_a), 32'd0);
    pulse_a(8'd255);
    wait_done(0, 300, "done255_seen");
    @(negedge clk);
    @(negedge clk);
    check("y_255", 32'(y_a), 32'd255);

    // start and value toggled mid-stream must not disturb the stream.
    streams_before = streams_a;
    pulse_a(8'd200);
    repeat (10) @(negedge clk);
    value_a = 8'd3;
    start_a = 1'b1;
    repeat (20) @(negedge clk);
    start_a = 1'b0;
    wait_done(0, 300, "done200_seen");
    repeat (10) @(negedge clk);
    check("y_200", 32'(y_a), 32'd200);
    check("no_extra_stream", 32'(streams_a - streams_before), 32'd1);

    // B: start held high gives two back-to-back streams.
    @(negedge clk);
    value_b = 8'd128;
    start_b = 1'b1;
    wait_done(1, 40, "b_done1_seen");
    first_v = bits_b;
    @(negedge clk);
    check("b_idle_gap", 32'(busy_b), 32'd0);
    @(negedge clk);
    check("b_restart", 32'(busy_b), 32'd1);
    start_b = 1'b0;
    wait_done(1, 40, "b_done2_seen");
    s = 8'd1;
    exp_v = '0;
    for (int i = 0; i < 16; i++) begin
      exp_v = {exp_v[15:0], (s <= 8'd128)};
      s = step8(s);
    end
    check("b_stream1", 32'(first_v), 32'(exp_v));
`ifdef BITSTREAM_RESEED_EN
    s = 8'd1;
`endif
    exp_v = '0;
    for (int i = 0; i < 16; i++) begin
      exp_v = {exp_v[15:0], (s <= 8'd128)};
      s = step8(s);
    end
    check("b_stream2", 32'(bits_b), 32'(exp_v));

    // Reset in the middle of a stream.
    pulse_a(8'd77);
    repeat (20) @(negedge clk);
    n_rst = 1'b0;
    #1;
    check("midrst_outs", {28'd0, bit_a, cap_a, busy_a, done_a}, 32'd0);
    check("midrst_lfsr", 32'(u_a.lfsr_q), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("midrst_no_done", 32'(dones_a), 32'd0);
    n_rst = 1'b1;
    pulse_a(8'd50);
    wait_done(0, 300, "done50_seen");
    @(negedge clk);
    @(negedge clk);
    check("y_50", 32'(y_a), 32'd50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
